// File: rtl/paddle_motion_ctrl.sv
// Turns raw paddle buttons into a per-frame go/up/down control stream for the paddle drawer.
// Buttons are synchronised and debounced; moves are paced to the frame tick and clamped on screen.
module paddle_motion_ctrl #(
  parameter int unsigned FRAME_CYCLES    = 833333,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP            = 2,
  parameter int unsigned Y_INIT          = 96,
  parameter int unsigned Y_MAX           = 192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       erase_done,
  output logic       go,
  output logic       up,
  output logic       down,
  output logic [7:0] paddle_y,
  output logic       frame_tick,
  output logic       busy
);

  localparam int unsigned FrameW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAME_CYCLES - 1);
  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0]        Step9     = 9'(STEP);
  localparam logic [8:0]        YMax9     = 9'(Y_MAX);
  localparam logic [7:0]        YInit     = 8'(Y_INIT);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StSample    = 2'd1;
  localparam logic [1:0] StEraseWait = 2'd2;
  localparam logic [1:0] StStepping  = 2'd3;

  // Bit 0 is the up key, bit 1 the down key throughout.
  logic [1:0]     meta_q, sync_q;
  logic [1:0]     pressed_sync;
  logic [1:0]     level_q, level_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;

  logic [1:0] state_q, state_d;
  logic       dir_dn_q, dir_dn_d;
  logic [3:0] n_q, n_d;
  logic       go_q, go_d;
  logic [7:0] y_q, y_d;

  logic       want_up, want_dn;
  logic [8:0] y9, room_dn, n_dn9, n_up9, sel_n9;

  // Inversion after the synchroniser so the metastable path carries the raw pin level.
  assign pressed_sync = ~sync_q;

  always_comb begin
    level_d = level_q;
    for (int k = 0; k < 2; k++) begin
      db_cnt_d[k] = '0;
      if (pressed_sync[k] != level_q[k]) begin
        if (db_cnt_q[k] == DbLast) begin
          level_d[k] = pressed_sync[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 2'b11;
      sync_q  <= 2'b11;
      level_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      meta_q  <= {key_down_n, key_up_n};
      sync_q  <= meta_q;
      level_q <= level_d;
      for (int k = 0; k < 2; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

  assign frame_tick  = (frame_cnt_q == FrameLast);
  assign frame_cnt_d = frame_tick ? '0 : frame_cnt_q + FrameW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign want_up = level_q[0] & ~level_q[1];
  assign want_dn = level_q[1] & ~level_q[0];

  // y never exceeds Y_MAX, so the down headroom cannot underflow.
  always_comb begin
    y9      = {1'b0, y_q};
    room_dn = YMax9 - y9;
    n_dn9   = (Step9 < room_dn) ? Step9 : room_dn;
    n_up9   = (Step9 < y9) ? Step9 : y9;
    sel_n9  = want_dn ? n_dn9 : n_up9;
  end

  always_comb begin
    state_d  = state_q;
    dir_dn_d = dir_dn_q;
    n_d      = n_q;
    go_d     = 1'b0;
    y_d      = y_q;
    case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if ((want_up || want_dn) && (sel_n9 != 9'd0)) begin
          dir_dn_d = want_dn;
          n_d      = sel_n9[3:0];
          go_d     = 1'b1;
          state_d  = StEraseWait;
        end else begin
          state_d = StIdle;
        end
      end
      StEraseWait: begin
        if (erase_done) begin
          state_d = StStepping;
        end
      end
      StStepping: begin
        y_d = dir_dn_q ? y_q + 8'd1 : y_q - 8'd1;
        n_d = n_q - 4'd1;
        if (n_q == 4'd1) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      dir_dn_q <= 1'b0;
      n_q      <= 4'd0;
      go_q     <= 1'b0;
      y_q      <= YInit;
    end else begin
      state_q  <= state_d;
      dir_dn_q <= dir_dn_d;
      n_q      <= n_d;
      go_q     <= go_d;
      y_q      <= y_d;
    end
  end

  assign go       = go_q;
  assign up       = (state_q == StStepping) && !dir_dn_q;
  assign down     = (state_q == StStepping) && dir_dn_q;
  assign busy     = (state_q != StIdle);
  assign paddle_y = y_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Bench for paddle_motion_ctrl: two instances (start Y 5 and 1) driven by directed and random
// frames, checked against a frame-level model of the paddle position and pulse counts.
module tb_paddle_motion_ctrl;

  localparam int STEP = 2;
  localparam int YMAX = 10;

  logic       clk;
  logic [1:0] rst_v;
  logic [1:0] key_up_n_v, key_dn_n_v, erase_v;
  logic [1:0] go_v, up_v, dn_v, tick_v, busy_v;
  logic [7:0] y_v [2];

  int n_checks = 0;
  int n_errors = 0;
  int model_y [2];

  int n_go   [2] = '{0, 0};
  int n_up   [2] = '{0, 0};
  int n_dn   [2] = '{0, 0};
  int n_tick [2] = '{0, 0};
  bit bad_seen [2] = '{1'b0, 1'b0};

  paddle_motion_ctrl #(
    .FRAME_CYCLES(16), .DEBOUNCE_CYCLES(4), .STEP(STEP), .Y_INIT(5), .Y_MAX(YMAX)
  ) u_dut (
    .clk(clk), .reset(rst_v[0]), .key_up_n(key_up_n_v[0]), .key_down_n(key_dn_n_v[0]),
    .erase_done(erase_v[0]), .go(go_v[0]), .up(up_v[0]), .down(dn_v[0]),
    .paddle_y(y_v[0]), .frame_tick(tick_v[0]), .busy(busy_v[0])
  );

  paddle_motion_ctrl #(
    .FRAME_CYCLES(16), .DEBOUNCE_CYCLES(4), .STEP(STEP), .Y_INIT(1), .Y_MAX(YMAX)
  ) u_dut_top (
    .clk(clk), .reset(rst_v[1]), .key_up_n(key_up_n_v[1]), .key_down_n(key_dn_n_v[1]),
    .erase_done(erase_v[1]), .go(go_v[1]), .up(up_v[1]), .down(dn_v[1]),
    .paddle_y(y_v[1]), .frame_tick(tick_v[1]), .busy(busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters and invariant watch, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      n_go[k]   <= n_go[k] + int'(go_v[k]);
      n_up[k]   <= n_up[k] + int'(up_v[k]);
      n_dn[k]   <= n_dn[k] + int'(dn_v[k]);
      n_tick[k] <= n_tick[k] + int'(tick_v[k]);
      if ((up_v[k] && dn_v[k]) || (go_v[k] && (up_v[k] || dn_v[k])) || int'(y_v[k]) > YMAX) begin
        bad_seen[k] <= 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_n(input int y, input bit up_p, input bit dn_p);
    if (up_p == dn_p) return 0;
    if (dn_p) return (YMAX - y < STEP) ? YMAX - y : STEP;
    return (y < STEP) ? y : STEP;
  endfunction

  task automatic wait_tick(input int w, input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (tick_v[w] === 1'b1) found = 1'b1;
    end
    chk({tag, " tick"}, 32'(found), 32'd1);
  endtask

  // One frame: wait for the tick, check go timing, answer with erase_done after d cycles,
  // then count the step pulses and compare the new position with the model.
  task automatic run_frame(input int w, input bit up_p, input bit dn_p, input int d,
                           input string tag);
    int  n, g0, u0, d0, cnt;
    bit  found;
    n = exp_n(model_y[w], up_p, dn_p);
    wait_tick(w, tag, found);
    if (!found) return;
    g0 = n_go[w];
    u0 = n_up[w];
    d0 = n_dn[w];
    step();
    chk({tag, " busy_sample"}, 32'(busy_v[w]), 32'd1);
    step();
    if (n == 0) begin
      chk({tag, " no_go"}, 32'(go_v[w]), 32'd0);
      chk({tag, " idle_again"}, 32'(busy_v[w]), 32'd0);
      repeat (4) step();
      chk({tag, " go_count"}, n_go[w] - g0, 32'd0);
      chk({tag, " y"}, 32'(y_v[w]), model_y[w]);
      return;
    end
    chk({tag, " go_at_tick+2"}, 32'(go_v[w]), 32'd1);
    repeat (d) step();
    erase_v[w] = 1'b1;
    step();
    erase_v[w] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if ((dn_p ? dn_v[w] : up_v[w]) !== 1'b1) break;
      cnt++;
      step();
    end
    model_y[w] = dn_p ? model_y[w] + n : model_y[w] - n;
    chk({tag, " pulses"}, cnt, n);
    chk({tag, " y"}, 32'(y_v[w]), model_y[w]);
    chk({tag, " go_count"}, n_go[w] - g0, 32'd1);
    chk({tag, " other_dir"}, dn_p ? n_up[w] - u0 : n_dn[w] - d0, 32'd0);
    chk({tag, " busy_end"}, 32'(busy_v[w]), 32'd0);
  endtask

  initial begin
    int  g0, u0, d0, t0, r, dly;
    bit  found, up_p, dn_p;

    key_up_n_v = 2'b11;
    key_dn_n_v = 2'b11;
    erase_v    = 2'b00;
    rst_v      = 2'b11;
    model_y[0] = 5;
    model_y[1] = 1;
    repeat (3) step();
    rst_v = 2'b00;

    chk("rst y", 32'(y_v[0]), 32'd5);
    chk("rst y_top", 32'(y_v[1]), 32'd1);
    chk("rst go", 32'(go_v[0]), 32'd0);
    chk("rst up", 32'(up_v[0]), 32'd0);
    chk("rst down", 32'(dn_v[0]), 32'd0);
    chk("rst busy", 32'(busy_v[0]), 32'd0);
    chk("rst tick", 32'(tick_v[0]), 32'd0);

    // Idle with keys released.
    t0 = n_tick[0]; g0 = n_go[0]; u0 = n_up[0]; d0 = n_dn[0];
    repeat (64) step();
    chk("idle ticks", n_tick[0] - t0, 32'd4);
    chk("idle go", n_go[0] - g0, 32'd0);
    chk("idle steps", (n_up[0] - u0) + (n_dn[0] - d0), 32'd0);
    chk("idle y", 32'(y_v[0]), 32'd5);

    // Up clamp at the top on the second instance.
    wait_tick(1, "top_align", found);
    key_up_n_v[1] = 1'b0;
    run_frame(1, 1'b1, 1'b0, 2, "top_clamp");
    run_frame(1, 1'b1, 1'b0, 1, "top_hold");
    key_up_n_v[1] = 1'b1;

    // Down moves up to the bottom clamp.
    wait_tick(0, "dn_align", found);
    key_dn_n_v[0] = 1'b0;
    run_frame(0, 1'b0, 1'b1, 3, "dn1");
    run_frame(0, 1'b0, 1'b1, int'($urandom_range(0, 3)), "dn2");
    run_frame(0, 1'b0, 1'b1, int'($urandom_range(0, 3)), "dn3");
    run_frame(0, 1'b0, 1'b1, 0, "dn4");

    // Both pressed, then released.
    key_up_n_v[0] = 1'b0;
    run_frame(0, 1'b1, 1'b1, 0, "both");
    key_up_n_v[0] = 1'b1;
    key_dn_n_v[0] = 1'b1;
    run_frame(0, 1'b0, 1'b0, 0, "release");

    // Stray erase_done while idle.
    u0 = n_up[0]; d0 = n_dn[0];
    erase_v[0] = 1'b1;
    step();
    erase_v[0] = 1'b0;
    step();
    chk("stray_erase steps", (n_up[0] - u0) + (n_dn[0] - d0), 32'd0);
    chk("stray_erase busy", 32'(busy_v[0]), 32'd0);

    // Two-cycle glitch must not be accepted.
    key_up_n_v[0] = 1'b0;
    step();
    step();
    key_up_n_v[0] = 1'b1;
    run_frame(0, 1'b0, 1'b0, 0, "glitch");

    // Up moves, one with erase_done withheld across two frame ticks.
    key_up_n_v[0] = 1'b0;
    run_frame(0, 1'b1, 1'b0, int'($urandom_range(0, 3)), "up1");
    run_frame(0, 1'b1, 1'b0, 40, "hold40");
    run_frame(0, 1'b1, 1'b0, int'($urandom_range(0, 3)), "up3");

    // Reset in the middle of a stepping burst.
    wait_tick(0, "rst_mid", found);
    step();
    step();
    chk("rst_mid go", 32'(go_v[0]), 32'd1);
    erase_v[0] = 1'b1;
    step();
    erase_v[0] = 1'b0;
    chk("rst_mid pulse1", 32'(up_v[0]), 32'd1);
    step();
    chk("rst_mid pulse2", 32'(up_v[0]), 32'd1);
    rst_v[0] = 1'b1;
    key_up_n_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    model_y[0] = 5;
    chk("rst_mid up", 32'(up_v[0]), 32'd0);
    chk("rst_mid y", 32'(y_v[0]), 32'd5);
    chk("rst_mid busy", 32'(busy_v[0]), 32'd0);
    g0 = n_go[0]; u0 = n_up[0]; d0 = n_dn[0];
    repeat (10) step();
    chk("rst_mid quiet", (n_go[0] - g0) + (n_up[0] - u0) + (n_dn[0] - d0), 32'd0);

    // Random key patterns and erase latencies.
    wait_tick(0, "rnd_align", found);
    for (int it = 0; it < 12; it++) begin
      r    = int'($urandom_range(0, 3));
      up_p = r[0];
      dn_p = r[1];
      dly  = int'($urandom_range(0, 3));
      key_up_n_v[0] = ~up_p;
      key_dn_n_v[0] = ~dn_p;
      run_frame(0, up_p, dn_p, dly, $sformatf("rnd%0d", it));
    end
    key_up_n_v[0] = 1'b1;
    key_dn_n_v[0] = 1'b1;

    chk("invariants main", 32'(bad_seen[0]), 32'd0);
    chk("invariants top", 32'(bad_seen[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
